// File: rtl/regfile_scoreboard.sv
// Register file with two bypassed combinational read ports, an ALU (A) and a
// load (B) write port, an optional hardwired zero register and a pending-load scoreboard.
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [AW-1:0]    Raddr1,
    input  logic [AW-1:0]    Raddr2,
    output logic [WIDTH-1:0] Read1,
    output logic [WIDTH-1:0] Read2,
    output logic             Busy1,
    output logic             Busy2,
    input  logic [AW-1:0]    WaddrA,
    input  logic [WIDTH-1:0] WdataA,
    input  logic             RegWrA,
    input  logic [AW-1:0]    WaddrB,
    input  logic [WIDTH-1:0] WdataB,
    input  logic             RegWrB,
    input  logic             Reserve,
    input  logic [AW-1:0]    ResAddr
);

    logic [WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0] pending_r;
    logic             wr_a_s;
    logic             wr_b_s;
    logic             res_s;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return ZERO_REG && (addr == {AW{1'b0}});
    endfunction

    function automatic logic [WIDTH-1:0] read_mux(
        input logic [AW-1:0]    ra,
        input logic [WIDTH-1:0] stored,
        input logic             wr_a,
        input logic [AW-1:0]    waddr_a,
        input logic [WIDTH-1:0] wdata_a,
        input logic             wr_b,
        input logic [AW-1:0]    waddr_b,
        input logic [WIDTH-1:0] wdata_b
    );
        logic [WIDTH-1:0] rd;
        if (is_zero_reg(ra)) begin
            rd = {WIDTH{1'b0}};
        end else if (wr_a && (waddr_a == ra)) begin
            rd = wdata_a;
        end else if (wr_b && (waddr_b == ra)) begin
            rd = wdata_b;
        end else begin
            rd = stored;
        end
        return rd;
    endfunction

    // A load being written back this cycle is already available through the bypass
    function automatic logic busy_mux(
        input logic [AW-1:0] ra,
        input logic          pend,
        input logic          wr_b,
        input logic [AW-1:0] waddr_b
    );
        logic bsy;
        if (is_zero_reg(ra)) begin
            bsy = 1'b0;
        end else if (wr_b && (waddr_b == ra)) begin
            bsy = 1'b0;
        end else begin
            bsy = pend;
        end
        return bsy;
    endfunction

    // Qualify write and reservation requests against the hardwired zero register
    always_comb begin
        wr_a_s = RegWrA  & ~is_zero_reg(WaddrA);
        wr_b_s = RegWrB  & ~is_zero_reg(WaddrB);
        res_s  = Reserve & ~is_zero_reg(ResAddr);
    end

    // Register array update; port A wins a same-address collision
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_b_s && !(wr_a_s && (WaddrA == WaddrB))) begin
                regs_r[WaddrB] <= WdataB;
            end
            if (wr_a_s) begin
                regs_r[WaddrA] <= WdataA;
            end
        end
    end

    // Scoreboard: a new reservation overrides a same-cycle load completion
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pending_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_b_s) begin
                pending_r[WaddrB] <= 1'b0;
            end
            if (res_s) begin
                pending_r[ResAddr] <= 1'b1;
            end
        end
    end

    // Read ports with bypass; held at zero while reset is asserted
    always_comb begin
        Read1 = {WIDTH{1'b0}};
        Read2 = {WIDTH{1'b0}};
        Busy1 = 1'b0;
        Busy2 = 1'b0;
        if (RESET) begin
            Read1 = read_mux(Raddr1, regs_r[Raddr1], RegWrA, WaddrA, WdataA,
                             RegWrB, WaddrB, WdataB);
            Read2 = read_mux(Raddr2, regs_r[Raddr2], RegWrA, WaddrA, WdataA,
                             RegWrB, WaddrB, WdataB);
            Busy1 = busy_mux(Raddr1, pending_r[Raddr1], RegWrB, WaddrB);
            Busy2 = busy_mux(Raddr2, pending_r[Raddr2], RegWrB, WaddrB);
        end else begin
            Read1 = {WIDTH{1'b0}};
            Read2 = {WIDTH{1'b0}};
            Busy1 = 1'b0;
            Busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: drives a ZERO_REG=0 and a ZERO_REG=1 instance in
// lockstep against a behavioural model, queueing expected read-port values per cycle.
module tb_regfile_scoreboard;

    logic        CLK;
    logic        RESET;
    logic [3:0]  Raddr1, Raddr2, WaddrA, WaddrB, ResAddr;
    logic [31:0] WdataA, WdataB;
    logic        RegWrA, RegWrB, Reserve;

    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic        bz1_0, bz2_0, bz1_1, bz2_1;

    int n_pass;
    int n_checks;

    logic [31:0] m_regs [2][16];
    logic        m_pend [2][16];

    typedef struct {
        logic [31:0] r1_0, r2_0, r1_1, r2_1;
        logic        b1_0, b2_0, b1_1, b2_1;
    } exp_t;

    exp_t exp_q [$];

    regfile_scoreboard #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .Raddr1(Raddr1), .Raddr2(Raddr2),
        .Read1(rd1_0), .Read2(rd2_0), .Busy1(bz1_0), .Busy2(bz2_0),
        .WaddrA(WaddrA), .WdataA(WdataA), .RegWrA(RegWrA),
        .WaddrB(WaddrB), .WdataB(WdataB), .RegWrB(RegWrB),
        .Reserve(Reserve), .ResAddr(ResAddr)
    );

    regfile_scoreboard #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .Raddr1(Raddr1), .Raddr2(Raddr2),
        .Read1(rd1_1), .Read2(rd2_1), .Busy1(bz1_1), .Busy2(bz2_1),
        .WaddrA(WaddrA), .WdataA(WdataA), .RegWrA(RegWrA),
        .WaddrB(WaddrB), .WdataB(WdataB), .RegWrB(RegWrB),
        .Reserve(Reserve), .ResAddr(ResAddr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input int z, input logic [3:0] ra);
        if (!RESET) return 32'd0;
        if (z == 1 && ra == 4'd0) return 32'd0;
        if (RegWrA && WaddrA == ra) return WdataA;
        if (RegWrB && WaddrB == ra) return WdataB;
        return m_regs[z][ra];
    endfunction

    function automatic logic exp_busy(input int z, input logic [3:0] ra);
        if (!RESET) return 1'b0;
        if (z == 1 && ra == 4'd0) return 1'b0;
        if (RegWrB && WaddrB == ra) return 1'b0;
        return m_pend[z][ra];
    endfunction

    task automatic model_clear();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[z][i] = 32'd0;
                m_pend[z][i] = 1'b0;
            end
        end
    endtask

    // Sequential overwrite order encodes "set beats clear" and "A beats B"
    task automatic model_edge();
        if (RESET) begin
            for (int z = 0; z < 2; z++) begin
                if (RegWrB && !(z == 1 && WaddrB == 4'd0)) m_pend[z][WaddrB] = 1'b0;
                if (Reserve && !(z == 1 && ResAddr == 4'd0)) m_pend[z][ResAddr] = 1'b1;
                if (RegWrB && !(z == 1 && WaddrB == 4'd0)) m_regs[z][WaddrB] = WdataB;
                if (RegWrA && !(z == 1 && WaddrA == 4'd0)) m_regs[z][WaddrA] = WdataA;
            end
        end
    endtask

    task automatic idle();
        Raddr1 = 4'd0; Raddr2 = 4'd0;
        WaddrA = 4'd0; WdataA = 32'd0; RegWrA = 1'b0;
        WaddrB = 4'd0; WdataB = 32'd0; RegWrB = 1'b0;
        Reserve = 1'b0; ResAddr = 4'd0;
    endtask

    task automatic rand_inputs();
        Raddr1  = 4'($urandom_range(15, 0));
        Raddr2  = 4'($urandom_range(15, 0));
        WaddrA  = 4'($urandom_range(15, 0));
        WaddrB  = 4'($urandom_range(15, 0));
        ResAddr = 4'($urandom_range(15, 0));
        WdataA  = $urandom;
        WdataB  = $urandom;
        RegWrA  = 1'($urandom_range(1, 0));
        RegWrB  = 1'($urandom_range(1, 0));
        Reserve = 1'($urandom_range(1, 0));
    endtask

    // Push model expectation for the current inputs, then compare once settled
    task automatic settle();
        exp_t e;
        exp_t g;
        e.r1_0 = exp_read(0, Raddr1); e.r2_0 = exp_read(0, Raddr2);
        e.r1_1 = exp_read(1, Raddr1); e.r2_1 = exp_read(1, Raddr2);
        e.b1_0 = exp_busy(0, Raddr1); e.b2_0 = exp_busy(0, Raddr2);
        e.b1_1 = exp_busy(1, Raddr1); e.b2_1 = exp_busy(1, Raddr2);
        exp_q.push_back(e);
        #2;
        g = exp_q.pop_front();
        check_eq("d0_read1", rd1_0, g.r1_0);
        check_eq("d0_read2", rd2_0, g.r2_0);
        check_eq("d1_read1", rd1_1, g.r1_1);
        check_eq("d1_read2", rd2_1, g.r2_1);
        check_eq("d0_busy1", {31'd0, bz1_0}, {31'd0, g.b1_0});
        check_eq("d0_busy2", {31'd0, bz2_0}, {31'd0, g.b2_0});
        check_eq("d1_busy1", {31'd0, bz1_1}, {31'd0, g.b1_1});
        check_eq("d1_busy2", {31'd0, bz2_1}, {31'd0, g.b2_1});
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        model_clear();
        idle();
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Activity while held in reset must be ignored
        for (int c = 0; c < 4; c++) begin
            rand_inputs();
            settle();
            tick();
        end
        RESET = 1'b1;
        for (int a = 0; a < 16; a++) begin
            idle();
            Raddr1 = 4'(a);
            Raddr2 = 4'(15 - a);
            settle();
            check_eq("rst_read", rd1_0, 32'd0);
            tick();
        end

        // Basic write with same-cycle bypass
        idle();
        RegWrA = 1'b1; WaddrA = 4'd3; WdataA = 32'hDEADBEEF;
        Raddr1 = 4'd3; Raddr2 = 4'd4;
        settle();
        check_eq("wr_bypass", rd1_0, 32'hDEADBEEF);
        check_eq("wr_other", rd2_0, 32'd0);
        tick();
        idle();
        Raddr1 = 4'd3; Raddr2 = 4'd4;
        settle();
        check_eq("wr_array", rd1_0, 32'hDEADBEEF);
        tick();

        // Collision: port A wins
        idle();
        RegWrA = 1'b1; WaddrA = 4'd5; WdataA = 32'h11;
        RegWrB = 1'b1; WaddrB = 4'd5; WdataB = 32'h22;
        Raddr1 = 4'd5;
        settle();
        check_eq("coll_bypass", rd1_0, 32'h11);
        tick();
        idle();
        RegWrA = 1'b1; WaddrA = 4'd6; WdataA = 32'h66;
        RegWrB = 1'b1; WaddrB = 4'd7; WdataB = 32'h77;
        Raddr1 = 4'd5;
        settle();
        check_eq("coll_array", rd1_0, 32'h11);
        tick();
        idle();
        Raddr1 = 4'd6; Raddr2 = 4'd7;
        settle();
        check_eq("dual_a", rd1_0, 32'h66);
        check_eq("dual_b", rd2_0, 32'h77);
        tick();

        // Scoreboard reserve / clear / simultaneous
        idle();
        Reserve = 1'b1; ResAddr = 4'd9; Raddr1 = 4'd9;
        settle();
        check_eq("res_lat", {31'd0, bz1_0}, 32'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            idle();
            Raddr1 = 4'd9;
            settle();
            check_eq("res_busy", {31'd0, bz1_0}, 32'd1);
            tick();
        end
        idle();
        RegWrB = 1'b1; WaddrB = 4'd9; WdataB = 32'h55; Raddr1 = 4'd9;
        settle();
        check_eq("clr_busy", {31'd0, bz1_0}, 32'd0);
        check_eq("clr_data", rd1_0, 32'h55);
        tick();
        idle();
        Raddr1 = 4'd9;
        settle();
        check_eq("clr_stay", {31'd0, bz1_0}, 32'd0);
        tick();
        idle();
        Reserve = 1'b1; ResAddr = 4'd9;
        RegWrB = 1'b1; WaddrB = 4'd9; WdataB = 32'h99; Raddr1 = 4'd9;
        settle();
        tick();
        idle();
        Raddr1 = 4'd9;
        settle();
        check_eq("set_wins", {31'd0, bz1_0}, 32'd1);
        check_eq("set_data", rd1_0, 32'h99);
        tick();

        // Zero register behaviour (dut1) versus ordinary register 0 (dut0)
        idle();
        RegWrA = 1'b1; WaddrA = 4'd1; WdataA = 32'h1234;
        settle();
        tick();
        idle();
        RegWrA = 1'b1; WaddrA = 4'd0; WdataA = 32'hFFFF;
        Reserve = 1'b1; ResAddr = 4'd0;
        Raddr1 = 4'd0; Raddr2 = 4'd1;
        settle();
        check_eq("z_bypass", rd1_1, 32'd0);
        tick();
        idle();
        Raddr1 = 4'd0; Raddr2 = 4'd1;
        settle();
        check_eq("z_read", rd1_1, 32'd0);
        check_eq("z_busy", {31'd0, bz1_1}, 32'd0);
        check_eq("z_addr1", rd2_1, 32'h1234);
        check_eq("nz_read", rd1_0, 32'hFFFF);
        check_eq("nz_busy", {31'd0, bz1_0}, 32'd1);
        tick();

        // Asynchronous reset between edges
        idle();
        RegWrA = 1'b1; WaddrA = 4'd2; WdataA = 32'hA5;
        Reserve = 1'b1; ResAddr = 4'd2;
        settle();
        tick();
        idle();
        Raddr1 = 4'd2;
        settle();
        check_eq("pre_rst_data", rd1_0, 32'hA5);
        check_eq("pre_rst_busy", {31'd0, bz1_0}, 32'd1);
        RESET = 1'b0;
        model_clear();
        #1;
        check_eq("arst_data", rd1_0, 32'd0);
        check_eq("arst_busy", {31'd0, bz1_0}, 32'd0);
        RESET = 1'b1;
        #1;
        check_eq("arst_held", rd1_0, 32'd0);
        tick();
        idle();
        Raddr1 = 4'd2; Raddr2 = 4'd3;
        settle();
        tick();

        // Randomised traffic against the model
        for (int c = 0; c < 300; c++) begin
            rand_inputs();
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the 16×32 general-purpose register file. It provides two combinational read ports and two clocked write ports: port A carries ALU writeback, port B carries memory-load writeback. Read-during-write bypass, an optional hardwired zero register and a per-register pending-write scoreboard support load-use hazard detection. It sits between decode (reads, reservations) and the two writeback paths in the processor datapath.

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 16, number of registers; power of two, at least 2
- AW, $clog2(DEPTH), address width (derived; do not override)
- ZERO_REG, 0, when 1 register 0 reads as 0, ignores writes and is never pending
- CLK  in  1  single clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- Raddr1, Raddr2  in  AW  read addresses
- Read1, Read2  out  WIDTH  read data (combinational, bypassed)
- Busy1, Busy2  out  1  register at Raddr1/Raddr2 has an outstanding load
- WaddrA  in  AW  port A write address
- WdataA  in  WIDTH  port A write data
- RegWrA  in  1  port A write enable
- WaddrB  in  AW  port B write address
- WdataB  in  WIDTH  port B write data
- RegWrB  in  1  port B write enable; also clears the pending bit
- Reserve  in  1  mark ResAddr pending (load issued)
- ResAddr  in  AW  register to reserve

## Operation
- State: regs[DEPTH] of WIDTH bits, plus pending[DEPTH] of 1 bit.
- Reset (RESET low): all regs = 0 and all pending = 0 immediately, independent of CLK. While RESET is low:
  - writes, reservations and bypass are ignored;
  - Read1/Read2 = 0 and Busy1/Busy2 = 0.
- Write: on posedge, if RegWrA then regs[WaddrA] <= WdataA; if RegWrB then regs[WaddrB] <= WdataB.
- Write collision (both enables, same address): port A wins, and port B data is dropped for that register.
- Read port n (combinational, priority order):
  1. ZERO_REG=1 and Raddr==0 gives 0.
  2. Otherwise, RegWrA and WaddrA==Raddr gives WdataA.
  3. Otherwise, RegWrB and WaddrB==Raddr gives WdataB.
  4. Otherwise, regs[Raddr].
- Scoreboard, on posedge:
  - RegWrB clears pending[WaddrB].
  - Reserve sets pending[ResAddr].
  - Same address in the same cycle: the set wins, because the new load is younger.
  - RegWrA does not touch pending.
- Busy n = pending[Raddr], except:
  - forced 0 when RegWrB and WaddrB==Raddr in the same cycle (bypass of the load data);
  - forced 0 for address 0 when ZERO_REG=1.
- ZERO_REG=1: writes and reservations to address 0 have no effect.
- ZERO_REG=0: register 0 is ordinary.
- Widths: addresses compare on all AW bits and data is stored unmodified, so there is no truncation or extension inside the block.

## Timing
- Read latency: 0 cycles. The value written at posedge k is visible from the register array from posedge k onward, and through the bypass during cycle k-1.
- Reservation latency: Busy rises in the cycle after the posedge that samples Reserve.
- Clear latency: Busy falls combinationally in the cycle RegWrB is presented, and stays low afterwards.
- Reset release: the first posedge with RESET high performs a normal update. Reservations and writes presented at that edge are accepted.
- Reset asserted mid-operation: any pending write is discarded and every pending bit is lost.

## Test plan
- Reset then read: assert RESET low with random CLK activity, then release. All 16 addresses read 0 and Busy reads 0.
- Basic write and read: WaddrA=3, WdataA=0xDEADBEEF for one cycle. Raddr1=3 shows 0xDEADBEEF in the same cycle (bypass) and in later cycles (array). Raddr2=4 still reads 0.
- Collision and priority: RegWrA and RegWrB both to address 5, with A=0x11 and B=0x22. During the cycle Read1=0x11; after the edge regs[5]=0x11. A separate case with both ports writing different addresses, 6 and 7, updates both.
- Scoreboard: Reserve at address 9, then Busy1 (Raddr1=9) is 1 for 3 cycles. RegWrB to 9 with 0x55 gives Busy1=0 and Read1=0x55 in that cycle, and Busy1 stays 0 after. Reserve and RegWrB to 9 in the same cycle leave Busy1=1.
- ZERO_REG=1 instance: write 0xFFFF to address 0 and Reserve 0. Read of 0 returns 0, Busy is 0, and address 1 is unaffected.
- Async reset mid-operation: write 0xA5 to address 2, Reserve 2, then pulse RESET low between clock edges. Read of 2 drops to 0 and Busy drops to 0 before the next posedge.
